// File: rtl/fwd_operand_stage_pkg.sv
// Shared pipeline constants and flattened-bus helpers for the operand forwarding stage.
package fwd_operand_stage_pkg;

  localparam int unsigned XLEN_DEF = 32;
  localparam int unsigned AW_DEF   = 5;
  localparam int unsigned SEL_RF   = 0;

  // Low bit of slice k in a bus of equal-width fields w bits wide.
  function automatic int unsigned slice_lo(input int unsigned k, input int unsigned w);
    return k * w;
  endfunction

endpackage

// File: rtl/fwd_operand_stage_prio_sel.sv
// Combinational priority selector: youngest valid producer matching addr wins, else rf data.
module fwd_prio_sel
  import fwd_operand_stage_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF,
  parameter int unsigned AW   = AW_DEF,
  parameter int unsigned NFWD = 2,
  parameter int unsigned SW   = $clog2(NFWD + 1)
) (
  input  logic [AW-1:0]        addr_i,
  input  logic [NFWD-1:0]      fwd_valid_i,
  input  logic [NFWD-1:0]      fwd_pending_i,
  input  logic [NFWD*AW-1:0]   fwd_rd_i,
  input  logic [NFWD*XLEN-1:0] fwd_data_i,
  input  logic [XLEN-1:0]      rf_data_i,
  output logic                 match_o,
  output logic [SW-1:0]        sel_o,
  output logic [XLEN-1:0]      data_o,
  output logic                 pend_o
);

  logic found;

  // Ascending scan; the first hit is latched by 'found' so index 0 has top priority.
  always_comb begin
    found   = 1'b0;
    match_o = 1'b0;
    sel_o   = SW'(SEL_RF);
    data_o  = rf_data_i;
    pend_o  = 1'b0;
    if (addr_i == '0) begin
      data_o = '0;
    end else begin
      for (int unsigned k = 0; k < NFWD; k++) begin
        if (!found && fwd_valid_i[k] &&
            (fwd_rd_i[slice_lo(k, AW) +: AW] == addr_i)) begin
          found  = 1'b1;
          sel_o  = SW'(k + 1);
          data_o = fwd_data_i[slice_lo(k, XLEN) +: XLEN];
          pend_o = fwd_pending_i[k];
        end
      end
      match_o = found;
    end
  end

endmodule

// File: rtl/fwd_operand_stage.sv
// ID/EX operand register with forwarding, load-use hazard, stall refresh and flush.
module fwd_operand_stage
  import fwd_operand_stage_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF,
  parameter int unsigned AW   = AW_DEF,
  parameter int unsigned NFWD = 2,
  parameter int unsigned SW   = $clog2(NFWD + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [AW-1:0]        rs_addr,
  input  logic [XLEN-1:0]      rf_data,
  input  logic [NFWD-1:0]      fwd_valid,
  input  logic [NFWD-1:0]      fwd_pending,
  input  logic [NFWD*AW-1:0]   fwd_rd,
  input  logic [NFWD*XLEN-1:0] fwd_data,
  input  logic                 stall,
  input  logic                 flush,
  output logic                 hazard,
  output logic                 out_valid,
  output logic [XLEN-1:0]      out_data,
  output logic [SW-1:0]        out_sel
);

  logic            ld_match, ld_pend, hd_match, hd_pend;
  logic [SW-1:0]   ld_sel, hd_sel;
  logic [XLEN-1:0] ld_data, hd_data;

  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] out_data_q, out_data_d;
  logic [SW-1:0]   out_sel_q, out_sel_d;
  logic [AW-1:0]   rs_hold_q, rs_hold_d;

  fwd_prio_sel #(.XLEN(XLEN), .AW(AW), .NFWD(NFWD), .SW(SW)) u_sel_load (
    .addr_i        (rs_addr),
    .fwd_valid_i   (fwd_valid),
    .fwd_pending_i (fwd_pending),
    .fwd_rd_i      (fwd_rd),
    .fwd_data_i    (fwd_data),
    .rf_data_i     (rf_data),
    .match_o       (ld_match),
    .sel_o         (ld_sel),
    .data_o        (ld_data),
    .pend_o        (ld_pend)
  );

  // Refresh path watches the rs captured at the last load, so a stalled operand can pick up late data.
  fwd_prio_sel #(.XLEN(XLEN), .AW(AW), .NFWD(NFWD), .SW(SW)) u_sel_hold (
    .addr_i        (rs_hold_q),
    .fwd_valid_i   (fwd_valid),
    .fwd_pending_i (fwd_pending),
    .fwd_rd_i      (fwd_rd),
    .fwd_data_i    (fwd_data),
    .rf_data_i     (rf_data),
    .match_o       (hd_match),
    .sel_o         (hd_sel),
    .data_o        (hd_data),
    .pend_o        (hd_pend)
  );

  assign hazard = in_valid & ld_match & ld_pend;

  // Next-state: flush > stall > load.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    rs_hold_d   = rs_hold_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (stall) begin
      if (out_valid_q && hd_match && !hd_pend) begin
        out_data_d = hd_data;
        out_sel_d  = hd_sel;
      end
    end else begin
      out_valid_d = in_valid & ~hazard;
      rs_hold_d   = rs_addr;
      if (!hazard) begin
        out_data_d = ld_data;
        out_sel_d  = ld_sel;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      rs_hold_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      rs_hold_q   <= rs_hold_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule

// File: doc/fwd_operand_stage.md
Name: fwd_operand_stage

Overview:
- Parametrised operand-forwarding block for the pipelined core; successor to the fixed 3-input 32-bit forwarding mux.
- Compares the requested source register against NFWD in-flight producer stages, picks the youngest valid match (or register-file data), and registers the operand into the next pipeline stage.
- Adds what a bare mux lacks: stall hold with in-place refresh, flush, x0 hard-zero and load-use hazard detection.
- One instance per source operand (rs1, rs2) at ID/EX.

Parameters:
- XLEN, 32, operand data width
- AW, 5, register address width
- NFWD, 2, number of forwarding sources; index 0 is youngest (EX/MEM), increasing index is older (MEM/WB, ...)
- SW, $clog2(NFWD+1), width of out_sel

Ports:
- clk  input  1  core clock, rising edge
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  upstream stage holds a valid instruction
- rs_addr  input  AW  source register address
- rf_data  input  XLEN  register-file read data for rs_addr
- fwd_valid  input  NFWD  bit k: source k writes a register
- fwd_pending  input  NFWD  bit k: source k's result is not yet available (load in flight)
- fwd_rd  input  NFWD*AW  flattened destination addresses; slice k = [k*AW +: AW]
- fwd_data  input  NFWD*XLEN  flattened result data; slice k = [k*XLEN +: XLEN]
- stall  input  1  hold the output register
- flush  input  1  kill the output register contents
- hazard  output  1  combinational: the selected match is pending; the stall controller must stall
- out_valid  output  1  registered operand is valid
- out_data  output  XLEN  registered operand
- out_sel  output  SW  registered source: 0 = register file or zero, k+1 = forward source k

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Reset: out_valid=0, out_data=0, out_sel=0. Reset overrides flush, stall and all other inputs.
- Match rule: source k matches when fwd_valid[k] & (fwd_rd[k]==rs_addr) & (rs_addr!=0).
- Selection: the lowest-index matching source wins (youngest data).
  - No match: rf_data is selected, sel=0.
  - rs_addr==0: data is 0 and sel=0, regardless of any forwarding source.
- hazard = in_valid & (a winning match exists) & fwd_pending[winner]. It is purely combinational.
  - A pending older source shadowed by a non-pending younger match does not raise hazard.
- Register update priority per rising edge: reset > flush > stall > load.
  - flush: out_valid<=0; out_data and out_sel hold their values. Flush overrides a simultaneous stall.
  - stall with out_valid=1: rs is held internally (captured at load).
    - If a held-rs match exists with its pending bit clear, out_data and out_sel refresh from it.
    - Otherwise all outputs hold.
    - This allows a load completing during a stall to update the held operand.
  - stall with out_valid=0: all outputs hold.
  - load (no stall, no flush): out_valid <= in_valid & ~hazard; out_data and out_sel take the selection.
    - With hazard=1 a bubble is inserted (out_valid=0) and data is not loaded.
- Latency: 1 cycle from inputs to out_*. hazard has 0 cycles of latency.
- Internal state: a held-rs register (AW bits), cleared to 0 on reset and loaded on every load edge.
- No storage beyond one stage; there are no full/empty conditions.
- Reset asserted mid-stall clears everything on that edge; the next edge after deassertion is a normal load.

Decomposition:
- Shared package/header (with the core's pipeline constants):
  - SEL_RF=0 encoding
  - XLEN and AW defaults
  - the slice macro/function for flattened buses
- One sub-module: fwd_prio_sel.
  - Combinational, parametrised.
  - Given addr, fwd_valid, fwd_pending, fwd_rd, fwd_data and rf_data, returns match, sel, data and pend.
  - Instantiated twice: once for rs_addr (load path) and once for the held rs (refresh path).
- Everything sequential stays in fwd_operand_stage.

Test Plan:
- Priority: NFWD=2, rs=5, fwd_valid=2'b11, both rd=5, data0=0xAAAA0000, data1=0x5555FFFF, pending=0 -> next cycle out_data=0xAAAA0000, out_sel=1, out_valid=1.
- x0 and no match: rs=0, fwd_rd0=0 valid, data0=0x1234, rf_data=0xDEAD -> out_data=0, out_sel=0. Then rs=7 with no match and rf_data=0xCAFE -> out_data=0xCAFE, out_sel=0.
- Load-use: rs=3 matches source 0 with pending=1 -> hazard=1 the same cycle, next cycle out_valid=0.
  - Next cycle pending=0, data0=0x77 -> out_valid=1, out_data=0x77, out_sel=1.
- Stall refresh: load rs=9 from rf_data=0x10. Assert stall 3 cycles; on cycle 2 source 1 rd=9, valid, data=0x99 -> out_data=0x99, out_sel=2 after that edge, held through the remaining stall.
- Flush vs stall: assert stall=1 and flush=1 together with out_valid=1 -> out_valid=0 next edge, out_data unchanged.
- Reset mid-operation: reset=1 during stall with out_valid=1, out_data=0x99 -> next edge all outputs 0. Release reset, rs=4, rf_data=0x44 -> out_data=0x44, out_valid=1 one cycle later. Repeat all tests with NFWD=3, XLEN=64.
